// File: rtl/cache_request_issuer_pkg.sv
// Shared definitions for the cache request issuer.
// Holds the bus widths shared by every node on the cache network, the
// issuer FSM state encoding and the layout of one queued core request.
package cache_request_issuer_pkg;

  localparam int DATA_WIDTH               = 8;
  localparam int CACHE_BANK_ADDRESS_WIDTH = 8;
  localparam int NETWORK_ADDRESS_WIDTH    = 4;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_READ = 1'b1
  } state_t;

  // One queued core request; write = 1 selects a store.
  typedef struct packed {
    logic                                write;
    logic [CACHE_BANK_ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]               data;
  } req_t;

  localparam int REQ_WIDTH = $bits(req_t);

endpackage

// File: rtl/cache_request_issuer_request_fifo.sv
// requestFifo: synchronous first-word-fall-through FIFO.
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   i_push, i_data    - write strobe and entry; ignored while full
//   i_pop             - drop the head entry; ignored while empty
//   o_data            - current head entry (valid when !o_empty)
//   o_full, o_empty   - occupancy flags
//   o_count           - number of stored entries (0..DEPTH)
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
module requestFifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  // A push into a full queue is refused even when a pop frees a slot on the
  // same edge; the producer simply retries next cycle.
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // NOTE: storage has no reset; the pointers and count define which entries
  // are meaningful, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // NOTE: every clocked assignment is non-blocking so all registers update
  // from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cache_request_issuer.sv
// cache_request_issuer: queues core load/store requests and issues them one
// at a time to the cache arbiter, allowing at most one outstanding read.
// Ports:
//   clk, reset                          - rising-edge clock, sync active-high reset
//   reqValid/reqReady/reqWrite/
//   reqAddress/reqData                  - core request handshake
//   respValid/respData/respAddress      - one-cycle read completion to the core
//   timeoutError                        - sticky: a read got no answer in time
//   memRead/memWrite/cacheAddressOut/
//   requesterAddressOut/dataOut         - registered arbiter request port
//   readReady/requesterAddressIn/
//   cacheDataIn                         - arbiter response port
module cache_request_issuer
  import cache_request_issuer_pkg::*;
#(
  parameter int MY_ADDRESS     = 0,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                reqValid,
  output logic                                reqReady,
  input  logic                                reqWrite,
  input  logic [CACHE_BANK_ADDRESS_WIDTH-1:0] reqAddress,
  input  logic [DATA_WIDTH-1:0]               reqData,
  output logic                                respValid,
  output logic [DATA_WIDTH-1:0]               respData,
  output logic [CACHE_BANK_ADDRESS_WIDTH-1:0] respAddress,
  output logic                                timeoutError,
  output logic                                memRead,
  output logic                                memWrite,
  output logic [CACHE_BANK_ADDRESS_WIDTH-1:0] cacheAddressOut,
  output logic [NETWORK_ADDRESS_WIDTH-1:0]    requesterAddressOut,
  output logic [DATA_WIDTH-1:0]               dataOut,
  input  logic                                readReady,
  input  logic [NETWORK_ADDRESS_WIDTH-1:0]    requesterAddressIn,
  input  logic [DATA_WIDTH-1:0]               cacheDataIn
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]                  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [NETWORK_ADDRESS_WIDTH-1:0] MY_NET   = NETWORK_ADDRESS_WIDTH'(MY_ADDRESS);

  state_t                              r_state;
  state_t                              w_next_state;
  req_t                                w_head;
  req_t                                w_push_entry;
  logic                                w_push;
  logic                                w_pop;
  logic                                w_empty;
  logic                                w_unused_full;  // readiness comes from the count
  logic [CNT_W-1:0]                    w_count;
  logic                                w_match;
  logic                                w_resp_take;
  logic                                w_timeout_fire;
  logic [TO_W-1:0]                     r_timer;
  logic [CACHE_BANK_ADDRESS_WIDTH-1:0] r_read_addr;

  assign reqReady     = (w_count < CNT_W'(FIFO_DEPTH));
  assign w_push       = reqValid & reqReady;
  assign w_push_entry = '{write: reqWrite, address: reqAddress, data: reqData};
  assign w_match      = readReady && (requesterAddressIn == MY_NET);

  requestFifo #(
    .WIDTH (REQ_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_entry),
    .o_data  (w_head),
    .o_full  (w_unused_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    w_next_state   = r_state;
    w_pop          = 1'b0;
    w_resp_take    = 1'b0;
    w_timeout_fire = 1'b0;
    case (r_state)
      IDLE: begin
        // Responses arriving here are stale or foreign and are dropped.
        if (!w_empty) begin
          w_pop = 1'b1;
          if (!w_head.write) w_next_state = WAIT_READ;
        end
      end
      WAIT_READ: begin
        // A matching response beats a timeout landing on the same edge.
        if (w_match) begin
          w_resp_take  = 1'b1;
          w_next_state = IDLE;
        end else if (r_timer == TO_LIMIT) begin
          w_timeout_fire = 1'b1;
          w_next_state   = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      memRead             <= 1'b0;
      memWrite            <= 1'b0;
      cacheAddressOut     <= '0;
      dataOut             <= '0;
      requesterAddressOut <= '0;
      respValid           <= 1'b0;
      respData            <= '0;
      respAddress         <= '0;
      timeoutError        <= 1'b0;
      r_timer             <= '0;
      r_read_addr         <= '0;
    end else begin
      memRead   <= w_pop & ~w_head.write;
      memWrite  <= w_pop & w_head.write;
      respValid <= w_resp_take;
      // Address/data lines hold their last issued values between issues.
      if (w_pop) begin
        cacheAddressOut     <= w_head.address;
        dataOut             <= w_head.data;
        requesterAddressOut <= MY_NET;
      end
      if (w_pop && !w_head.write) begin
        r_read_addr <= w_head.address;
        r_timer     <= '0;
      end else if (r_state == WAIT_READ && r_timer != '1) begin
        r_timer <= r_timer + TO_W'(1);
      end
      if (w_resp_take) begin
        respData    <= cacheDataIn;
        respAddress <= r_read_addr;
      end
      if (w_timeout_fire) timeoutError <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_request_issuer.sv
// Directed bench for cache_request_issuer (node address 3, depth 4,
// timeout 15): a per-cycle vector table for the basic write/read paths and
// hand-written sequences for timeout, full queue and mid-read reset.
module tb_cache_request_issuer;
  import cache_request_issuer_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int AW = CACHE_BANK_ADDRESS_WIDTH;
  localparam int NW = NETWORK_ADDRESS_WIDTH;

  logic          clk = 1'b0;
  logic          reset;
  logic          reqValid, reqReady, reqWrite;
  logic [AW-1:0] reqAddress;
  logic [DW-1:0] reqData;
  logic          respValid;
  logic [DW-1:0] respData;
  logic [AW-1:0] respAddress;
  logic          timeoutError;
  logic          memRead, memWrite;
  logic [AW-1:0] cacheAddressOut;
  logic [NW-1:0] requesterAddressOut;
  logic [DW-1:0] dataOut;
  logic          readReady;
  logic [NW-1:0] requesterAddressIn;
  logic [DW-1:0] cacheDataIn;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic          rst, valid, write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          rr;
    logic [NW-1:0] rai;
    logic [DW-1:0] cdi;
  } in_t;

  typedef struct packed {
    logic          ready, mrd, mwr;
    logic [AW-1:0] cao;
    logic [DW-1:0] dout;
    logic [NW-1:0] rao;
    logic          rv;
    logic [DW-1:0] rdata;
    logic [AW-1:0] raddr;
    logic          terr;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  cache_request_issuer #(
    .MY_ADDRESS     (3),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (15)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .reqValid            (reqValid),
    .reqReady            (reqReady),
    .reqWrite            (reqWrite),
    .reqAddress          (reqAddress),
    .reqData             (reqData),
    .respValid           (respValid),
    .respData            (respData),
    .respAddress         (respAddress),
    .timeoutError        (timeoutError),
    .memRead             (memRead),
    .memWrite            (memWrite),
    .cacheAddressOut     (cacheAddressOut),
    .requesterAddressOut (requesterAddressOut),
    .dataOut             (dataOut),
    .readReady           (readReady),
    .requesterAddressIn  (requesterAddressIn),
    .cacheDataIn         (cacheDataIn)
  );

  always #5 clk = ~clk;

  function automatic in_t mk_in(input logic rst, input logic valid, input logic write,
                                input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                input logic rr, input logic [NW-1:0] rai,
                                input logic [DW-1:0] cdi);
    in_t v;
    v.rst = rst; v.valid = valid; v.write = write; v.addr = addr; v.data = data;
    v.rr = rr; v.rai = rai; v.cdi = cdi;
    return v;
  endfunction

  function automatic out_t mk_out(input logic ready, input logic mrd, input logic mwr,
                                  input logic [AW-1:0] cao, input logic [DW-1:0] dout,
                                  input logic [NW-1:0] rao, input logic rv,
                                  input logic [DW-1:0] rdata, input logic [AW-1:0] raddr,
                                  input logic terr);
    out_t v;
    v.ready = ready; v.mrd = mrd; v.mwr = mwr; v.cao = cao; v.dout = dout;
    v.rao = rao; v.rv = rv; v.rdata = rdata; v.raddr = raddr; v.terr = terr;
    return v;
  endfunction

  function automatic out_t sample();
    return mk_out(reqReady, memRead, memWrite, cacheAddressOut, dataOut,
                  requesterAddressOut, respValid, respData, respAddress, timeoutError);
  endfunction

  task automatic drive(input in_t v);
    reset              = v.rst;
    reqValid           = v.valid;
    reqWrite           = v.write;
    reqAddress         = v.addr;
    reqData            = v.data;
    readReady          = v.rr;
    requesterAddressIn = v.rai;
    cacheDataIn        = v.cdi;
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input out_t exp);
    check(name, 64'(sample()), 64'(exp));
  endtask

  vec_t tbl[15];
  in_t  idle;

  initial begin
    idle = mk_in(0, 0, 0, 8'h00, 8'h00, 0, 4'h0, 8'h00);

    // Basic table: reset, single write, read round trip, stray response
    // in IDLE, back-to-back writes.
    tbl[0]  = '{mk_in(1, 0, 0, 8'h00, 8'h00, 0, 4'h0, 8'h00), mk_out(1, 0, 0, 8'h00, 8'h00, 4'h0, 0, 8'h00, 8'h00, 0)};
    tbl[1]  = '{mk_in(0, 1, 1, 8'h05, 8'hA5, 0, 4'h0, 8'h00), mk_out(1, 0, 0, 8'h00, 8'h00, 4'h0, 0, 8'h00, 8'h00, 0)};
    tbl[2]  = '{idle,                                         mk_out(1, 0, 1, 8'h05, 8'hA5, 4'h3, 0, 8'h00, 8'h00, 0)};
    tbl[3]  = '{idle,                                         mk_out(1, 0, 0, 8'h05, 8'hA5, 4'h3, 0, 8'h00, 8'h00, 0)};
    tbl[4]  = '{mk_in(0, 1, 0, 8'h09, 8'h00, 0, 4'h0, 8'h00), mk_out(1, 0, 0, 8'h05, 8'hA5, 4'h3, 0, 8'h00, 8'h00, 0)};
    tbl[5]  = '{idle,                                         mk_out(1, 1, 0, 8'h09, 8'h00, 4'h3, 0, 8'h00, 8'h00, 0)};
    tbl[6]  = '{idle,                                         mk_out(1, 0, 0, 8'h09, 8'h00, 4'h3, 0, 8'h00, 8'h00, 0)};
    tbl[7]  = '{idle,                                         mk_out(1, 0, 0, 8'h09, 8'h00, 4'h3, 0, 8'h00, 8'h00, 0)};
    tbl[8]  = '{mk_in(0, 0, 0, 8'h00, 8'h00, 1, 4'h3, 8'h3C), mk_out(1, 0, 0, 8'h09, 8'h00, 4'h3, 1, 8'h3C, 8'h09, 0)};
    tbl[9]  = '{idle,                                         mk_out(1, 0, 0, 8'h09, 8'h00, 4'h3, 0, 8'h3C, 8'h09, 0)};
    tbl[10] = '{mk_in(0, 0, 0, 8'h00, 8'h00, 1, 4'h3, 8'h77), mk_out(1, 0, 0, 8'h09, 8'h00, 4'h3, 0, 8'h3C, 8'h09, 0)};
    tbl[11] = '{mk_in(0, 1, 1, 8'h01, 8'h11, 0, 4'h0, 8'h00), mk_out(1, 0, 0, 8'h09, 8'h00, 4'h3, 0, 8'h3C, 8'h09, 0)};
    tbl[12] = '{mk_in(0, 1, 1, 8'h02, 8'h22, 0, 4'h0, 8'h00), mk_out(1, 0, 1, 8'h01, 8'h11, 4'h3, 0, 8'h3C, 8'h09, 0)};
    tbl[13] = '{idle,                                         mk_out(1, 0, 1, 8'h02, 8'h22, 4'h3, 0, 8'h3C, 8'h09, 0)};
    tbl[14] = '{idle,                                         mk_out(1, 0, 0, 8'h02, 8'h22, 4'h3, 0, 8'h3C, 8'h09, 0)};

    for (int k = 0; k < 15; k++) begin
      drive(tbl[k].i);
      tick();
      check_out($sformatf("vec%0d", k), tbl[k].o);
    end

    // Matching response exactly on the timeout edge wins.
    drive(mk_in(0, 1, 0, 8'h21, 8'h00, 0, 4'h0, 8'h00));
    tick();
    drive(idle);
    tick();
    check("edge_rd_issue", {memRead, cacheAddressOut}, {1'b1, 8'h21});
    for (int i = 1; i <= 15; i++) begin
      tick();
      check($sformatf("edge_wait%0d", i), {respValid, timeoutError}, 2'b00);
    end
    drive(mk_in(0, 0, 0, 8'h00, 8'h00, 1, 4'h3, 8'h5A));
    tick();
    check("edge_resp", {respValid, respData, respAddress, timeoutError}, {1'b1, 8'h5A, 8'h21, 1'b0});
    drive(idle);
    tick();
    check("edge_after", {respValid, timeoutError}, 2'b00);

    // Full queue while a read is outstanding; W5 must never enter.
    drive(mk_in(0, 1, 0, 8'h30, 8'h00, 0, 4'h0, 8'h00));
    tick();
    for (int k = 1; k <= 5; k++) begin
      drive(mk_in(0, 1, 1, 8'(8'h50 + k), 8'(8'hD0 + k), 0, 4'h0, 8'h00));
      tick();
      if (k == 1) check("full_rd_issue", {memRead, cacheAddressOut}, {1'b1, 8'h30});
      check($sformatf("full_ready%0d", k), reqReady, (k < 4) ? 1'b1 : 1'b0);
    end
    drive(mk_in(0, 1, 1, 8'h55, 8'hD5, 1, 4'h3, 8'h0F));
    tick();
    check("full_resp", {respValid, respData, respAddress, reqReady}, {1'b1, 8'h0F, 8'h30, 1'b0});
    drive(mk_in(0, 1, 1, 8'h55, 8'hD5, 0, 4'h0, 8'h00));
    tick();
    check("full_wr1", {memWrite, cacheAddressOut, dataOut, reqReady}, {1'b1, 8'h51, 8'hD1, 1'b1});
    drive(idle);
    for (int k = 2; k <= 4; k++) begin
      tick();
      check($sformatf("full_wr%0d", k), {memWrite, cacheAddressOut, dataOut},
            {1'b1, 8'(8'h50 + k), 8'(8'hD0 + k)});
    end
    tick();
    check("full_drained", {memWrite, memRead, cacheAddressOut}, {1'b0, 1'b0, 8'h54});

    // Reset while waiting for a read; its later response is ignored.
    drive(mk_in(0, 1, 0, 8'h44, 8'h00, 0, 4'h0, 8'h00));
    tick();
    drive(idle);
    tick();
    check("rst_rd_issue", {memRead, cacheAddressOut}, {1'b1, 8'h44});
    tick();
    drive(mk_in(1, 0, 0, 8'h00, 8'h00, 0, 4'h0, 8'h00));
    tick();
    check_out("rst_outputs", mk_out(1, 0, 0, 8'h00, 8'h00, 4'h0, 0, 8'h00, 8'h00, 0));
    drive(mk_in(0, 0, 0, 8'h00, 8'h00, 1, 4'h3, 8'hEE));
    tick();
    check_out("rst_late_resp", mk_out(1, 0, 0, 8'h00, 8'h00, 4'h0, 0, 8'h00, 8'h00, 0));

    // Foreign response only, then timeout after the full wait.
    drive(mk_in(0, 1, 0, 8'h40, 8'h00, 0, 4'h0, 8'h00));
    tick();
    drive(idle);
    tick();
    check("to_rd_issue", {memRead, cacheAddressOut}, {1'b1, 8'h40});
    for (int i = 1; i <= 16; i++) begin
      drive((i == 3) ? mk_in(0, 0, 0, 8'h00, 8'h00, 1, 4'h5, 8'h99) : idle);
      tick();
      check($sformatf("to_rv%0d", i), respValid, 1'b0);
      check($sformatf("to_err%0d", i), timeoutError, (i == 16) ? 1'b1 : 1'b0);
    end
    drive(idle);
    tick();
    check("to_sticky", {timeoutError, memRead, respValid}, 3'b100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
